// File: rtl/instr_encoder_if.sv
// Handshake bundle between a record producer, the instruction encoder and the
// word consumer. The master modport is the producer/consumer side.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_group;
  logic [3:0]  in_opcode;
  logic [3:0]  in_ra;
  logic [3:0]  in_rb;
  logic [3:0]  in_rc;
  logic [31:0] in_imm;
  logic        in_li;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_bad;
  logic [15:0] words_out;

  modport master (
    output in_valid, in_group, in_opcode, in_ra, in_rb, in_rc, in_imm, in_li,
    output out_ready,
    input  in_ready, out_valid, out_word, out_bad, words_out
  );

  modport slave (
    input  in_valid, in_group, in_opcode, in_ra, in_rb, in_rc, in_imm, in_li,
    input  out_ready,
    output in_ready, out_valid, out_word, out_bad, words_out
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded-field records into Frost32 instruction words, expanding the
// load-immediate pseudo-op into one or two group-1 words, behind an output FIFO.
module instr_encoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [3:0]  OPC_CPYHI  = 4'hE,
  parameter logic [3:0]  OPC_ORI    = 4'h5
) (
  input logic           clk,
  input logic           rst_n,
  instr_encoder_if.slave bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, LI_LO} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   mem_word [FIFO_DEPTH];
  logic          mem_bad  [FIFO_DEPTH];
  logic [3:0]    li_ra_q;
  logic [15:0]   li_lo_q;
  logic [15:0]   words_q;

  logic        fifo_space;
  logic        in_ready;
  logic        push, pop;
  logic [31:0] push_word;
  logic        push_bad;
  logic [31:0] enc_word;
  logic        enc_bad;
  logic        li_two;

  assign fifo_space = (count < DEPTH_C);
  assign pop        = (count != '0) && bus.out_ready;
  assign li_two     = |bus.in_imm[31:16];

  // Plain (non-li) record encoding.
  always_comb begin
    enc_word = '0;
    enc_bad  = 1'b0;
    case (bus.in_group)
      4'd0, 4'd3, 4'd4, 4'd6: begin
        enc_word = {bus.in_group, bus.in_ra, bus.in_rb, bus.in_rc, bus.in_opcode, 12'h000};
      end
      4'd1, 4'd2: begin
        enc_word = {bus.in_group, bus.in_ra, bus.in_rb, bus.in_opcode, bus.in_imm[15:0]};
        enc_bad  = !((&bus.in_imm[31:16]) || (~|bus.in_imm[31:16]));
      end
      4'd5: begin
        enc_word = {bus.in_group, bus.in_ra, bus.in_rb, bus.in_rc, bus.in_opcode, bus.in_imm[11:0]};
        enc_bad  = !((&bus.in_imm[31:11]) || (~|bus.in_imm[31:11]));
      end
      default: begin
        enc_word = '0;
        enc_bad  = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    push      = 1'b0;
    push_word = '0;
    push_bad  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = fifo_space;
        if (bus.in_valid && fifo_space) begin
          push = 1'b1;
          if (bus.in_li) begin
            if (li_two) begin
              push_word = {4'h1, bus.in_ra, 4'h0, OPC_CPYHI, bus.in_imm[31:16]};
              state_d   = LI_LO;
            end else begin
              push_word = {4'h1, bus.in_ra, 4'h0, OPC_ORI, bus.in_imm[15:0]};
            end
          end else begin
            push_word = enc_word;
            push_bad  = enc_bad;
          end
        end
      end
      LI_LO: begin
        if (fifo_space) begin
          push      = 1'b1;
          push_word = {4'h1, li_ra_q, li_ra_q, OPC_ORI, li_lo_q};
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      li_ra_q <= '0;
      li_lo_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.in_valid && fifo_space && bus.in_li) begin
        li_ra_q <= bus.in_ra;
        li_lo_q <= bus.in_imm[15:0];
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_word[wr_ptr] <= push_word;
      mem_bad[wr_ptr]  <= push_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      words_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        words_q <= words_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (count != '0);
  assign bus.out_word  = (count != '0) ? mem_word[rd_ptr] : '0;
  assign bus.out_bad   = (count != '0) ? mem_bad[rd_ptr]  : 1'b0;
  assign bus.words_out = words_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed layout/backpressure/reset cases plus
// randomized records scored against an arithmetic reference model.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_encoder_if bus ();

  instr_encoder #(
    .FIFO_DEPTH(4),
    .OPC_CPYHI (4'hE),
    .OPC_ORI   (4'h5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];
  int unsigned model_popped = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: words computed from field positions with plain arithmetic.
  function automatic void model_push(input logic [3:0] g, input logic [3:0] op,
                                     input logic [3:0] ra, input logic [3:0] rb,
                                     input logic [3:0] rc, input logic [31:0] imm,
                                     input logic li);
    longint unsigned w;
    longint unsigned gu = g, opu = op, rau = ra, rbu = rb, rcu = rc;
    longint unsigned hi = imm / 65536;
    longint unsigned lo = imm % 65536;
    int signed simm = imm;
    bit bad = 0;
    if (li) begin
      if (hi == 0) begin
        w = 1 * 2**28 + rau * 2**24 + 5 * 2**16 + lo;
        exp_q.push_back({1'b0, 32'(w)});
      end else begin
        w = 1 * 2**28 + rau * 2**24 + 14 * 2**16 + hi;
        exp_q.push_back({1'b0, 32'(w)});
        w = 1 * 2**28 + rau * 2**24 + rau * 2**20 + 5 * 2**16 + lo;
        exp_q.push_back({1'b0, 32'(w)});
      end
      return;
    end
    if (gu == 1 || gu == 2) begin
      w = gu * 2**28 + rau * 2**24 + rbu * 2**20 + opu * 2**16 + lo;
      bad = !(hi == 0 || hi == 65535);
    end else if (gu == 5) begin
      w = gu * 2**28 + rau * 2**24 + rbu * 2**20 + rcu * 2**16 + opu * 2**12 + (imm % 4096);
      bad = (simm < -2048) || (simm > 2047);
    end else if (gu <= 6) begin
      w = gu * 2**28 + rau * 2**24 + rbu * 2**20 + rcu * 2**16 + opu * 2**12;
    end else begin
      w = 0;
      bad = 1;
    end
    exp_q.push_back({bad, 32'(w)});
  endfunction

  // One clock: observe handshakes away from the edge, then advance to the next negedge.
  task automatic clk_step(output bit accepted);
    bit popped;
    #1;
    accepted = bus.in_valid && bus.in_ready;
    popped   = bus.out_valid && bus.out_ready;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_word", bus.out_valid, 0);
      else chk("head", {bus.out_bad, bus.out_word}, exp_q[0]);
    end
    if (popped) begin
      model_popped++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] g, input logic [3:0] op, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [3:0] rc, input logic [31:0] imm,
                      input logic li, input bit rand_rdy);
    bit acc = 0;
    int n = 0;
    bus.in_group = g; bus.in_opcode = op; bus.in_ra = ra; bus.in_rb = rb;
    bus.in_rc = rc; bus.in_imm = imm; bus.in_li = li; bus.in_valid = 1'b1;
    while (!acc && n < 64) begin
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
      clk_step(acc);
      n++;
    end
    bus.in_valid = 1'b0;
    if (acc) model_push(g, op, ra, rb, rc, imm, li);
    else chk("accept_timeout", acc, 1);
  endtask

  task automatic drain();
    bit d;
    int n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 64) begin
      clk_step(d);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_valid", bus.out_valid, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    model_popped = 0;
    @(negedge clk);
  endtask

  // Accept with the FIFO empty, then inspect the head one cycle later.
  task automatic dir_single(input string tag, input logic [3:0] g, input logic [3:0] op,
                            input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                            input logic [31:0] imm, input logic li,
                            input logic [31:0] exp_word, input logic exp_bad);
    bus.out_ready = 1'b0;
    send(g, op, ra, rb, rc, imm, li, 0);
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_word"}, bus.out_word, exp_word);
    chk({tag, "_bad"}, bus.out_bad, exp_bad);
    drain();
  endtask

  initial begin
    bit a;
    int acc_cnt;
    logic [3:0] g;
    logic [31:0] imm;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_group = '0; bus.in_opcode = '0; bus.in_ra = '0;
    bus.in_rb = '0; bus.in_rc = '0; bus.in_imm = '0; bus.in_li = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_word", bus.out_word, 0);
    chk("rst_out_bad", bus.out_bad, 0);
    chk("rst_words_out", bus.words_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);

    dir_single("g0", 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 32'h0, 1'b0, 32'h0123_0000, 1'b0);
    dir_single("g1", 4'd1, 4'd0, 4'd4, 4'd5, 4'd0, 32'h0000_1234, 1'b0, 32'h1450_1234, 1'b0);
    dir_single("g1bad", 4'd1, 4'd3, 4'd4, 4'd5, 4'd0, 32'h0001_0000, 1'b0, 32'h1453_0000, 1'b1);
    dir_single("g2neg", 4'd2, 4'd1, 4'd6, 4'd7, 4'd0, 32'hFFFF_8000, 1'b0, 32'h2671_8000, 1'b0);
    dir_single("g5neg", 4'd5, 4'd0, 4'd1, 4'd2, 4'd3, 32'hFFFF_FFFC, 1'b0, 32'h5123_0FFC, 1'b0);
    dir_single("g5bad", 4'd5, 4'd0, 4'd1, 4'd2, 4'd3, 32'h0000_0800, 1'b0, 32'h5123_0800, 1'b1);
    dir_single("g5max", 4'd5, 4'd2, 4'd1, 4'd2, 4'd3, 32'h0000_07FF, 1'b0, 32'h5123_27FF, 1'b0);
    dir_single("g9", 4'd9, 4'd7, 4'd8, 4'd9, 4'd10, 32'hABCD_1234, 1'b0, 32'h0000_0000, 1'b1);
    dir_single("li_short", 4'd3, 4'd9, 4'd3, 4'd9, 4'd9, 32'h0000_00FF, 1'b1, 32'h1305_00FF, 1'b0);
    chk("li_short_in_ready", bus.in_ready, 1);

    // Two-word li: in_ready low for exactly the LI_LO cycle.
    bus.out_ready = 1'b0;
    send(4'd0, 4'd0, 4'd7, 4'd1, 4'd1, 32'hDEAD_BEEF, 1'b1, 0);
    chk("li_hi_word", bus.out_word, 32'h170E_DEAD);
    chk("li_lo_busy", bus.in_ready, 0);
    clk_step(a);
    chk("li_back_idle", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    clk_step(a);
    bus.out_ready = 1'b0;
    chk("li_lo_word", bus.out_word, 32'h1775_BEEF);
    chk("li_lo_bad", bus.out_bad, 0);
    drain();

    // Backpressure: only FIFO_DEPTH records fit while the consumer stalls.
    do_reset();
    bus.out_ready = 1'b0;
    acc_cnt = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      bus.in_group = 4'd0; bus.in_opcode = 4'(acc_cnt); bus.in_ra = 4'(acc_cnt + 1);
      bus.in_rb = 4'd2; bus.in_rc = 4'd3; bus.in_imm = '0; bus.in_li = 1'b0;
      bus.in_valid = 1'b1;
      clk_step(a);
      if (a) begin
        model_push(4'd0, 4'(acc_cnt), 4'(acc_cnt + 1), 4'd2, 4'd3, 32'h0, 1'b0);
        acc_cnt++;
      end
    end
    chk("bp_accepted", acc_cnt, 4);
    chk("bp_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 32 && acc_cnt < 6; cyc++) begin
      bus.in_group = 4'd0; bus.in_opcode = 4'(acc_cnt); bus.in_ra = 4'(acc_cnt + 1);
      bus.in_valid = 1'b1;
      clk_step(a);
      if (a) begin
        model_push(4'd0, 4'(acc_cnt), 4'(acc_cnt + 1), 4'd2, 4'd3, 32'h0, 1'b0);
        acc_cnt++;
      end
    end
    bus.in_valid = 1'b0;
    chk("bp_all_accepted", acc_cnt, 6);
    drain();
    chk("bp_words_out", bus.words_out, 6);

    // Reset during LI_LO drops the pending low word.
    bus.out_ready = 1'b0;
    send(4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 32'h1234_5678, 1'b1, 0);
    chk("mid_li_busy", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_word", bus.out_word, 0);
    chk("mid_rst_bad", bus.out_bad, 0);
    chk("mid_rst_words_out", bus.words_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    model_popped = 0;
    bus.out_ready = 1'b1;
    repeat (4) clk_step(a);
    chk("mid_rst_no_ori", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_words_after", bus.words_out, 0);

    // Randomized records with random consumer stalls.
    for (int i = 0; i < 300; i++) begin
      g = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: imm = 32'($urandom_range(0, 65535));
        2: imm = 32'hFFFF_0000 | 32'($urandom_range(0, 65535));
        default: imm = $urandom;
      endcase
      send(g, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), imm,
           ($urandom_range(0, 4) == 0), 1);
      if ($urandom_range(0, 3) == 0) clk_step(a);
    end
    drain();
    chk("rand_words_out", bus.words_out, 16'(model_popped));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming instruction encoder: accepts decoded-field records over a valid/ready handshake and packs them into 32-bit Frost32 instruction words, using the same field layout the instruction decoder unpacks. A load-32-bit-immediate pseudo-op expands into one or two group-1 words through a small FSM. Encoded words pass through an output FIFO to a valid/ready consumer (instruction memory writer, trace replay, or bench driver).

## Interface
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `OPC_CPYHI`, 4'hE: group-1 opcode that writes imm16 to `ra[31:16]` and clears `ra[15:0]`.
- `OPC_ORI`, 4'h5: group-1 opcode for zero-extended OR-immediate.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input record valid.
- `in_ready`  out  1  encoder accepts a record this cycle.
- `in_group`  in  4  instruction group, 0..6 legal.
- `in_opcode`  in  4  opcode within the group.
- `in_ra`, `in_rb`, `in_rc`  in  4 each  register indices.
- `in_imm`  in  32  immediate; low bits used per group.
- `in_li`  in  1  pseudo-op: load `in_imm` into `in_ra`. Group, opcode, rb and rc are ignored.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes head.
- `out_word`  out  32  encoded instruction.
- `out_bad`  out  1  head word came from an illegal record.
- `words_out`  out  16  count of words popped, wraps.

## Operation
- Word layouts:
  - Group field is always `[31:28]`; `ra` is `[27:24]`; `rb` is `[23:20]`.
  - Groups 0, 3, 4, 6: `rc` `[19:16]`, opcode `[15:12]`, `[11:0]` = 0.
  - Groups 1, 2: opcode `[19:16]`, `imm[15:0]` in `[15:0]`.
  - Group 5: `rc` `[19:16]`, opcode `[15:12]`, `imm[11:0]` in `[11:0]`.
- Bad flag:
  - Group 5 sets bad when `in_imm` is not the sign-extension of `in_imm[11:0]`; the word is still encoded.
  - Groups 1 and 2 set bad when `in_imm[31:16]` is neither all-0 nor all-1.
  - Groups 7..15 emit word 0x0000_0000 (NOP) with bad = 1.
- Pseudo-op `in_li`:
  - If `in_imm[31:16]` == 0: emit one word, ori `ra`, r0, `imm[15:0]`.
  - Otherwise emit two words in order:
    1. cpyhi `ra`, r0, `imm[31:16]` (`rb` = 0).
    2. ori `ra`, `ra`, `imm[15:0]`.
  - bad = 0 for both words.
- FSM states:
  - IDLE: `in_ready` = 1 when FIFO count ≤ DEPTH−1. An accepted two-word li pushes the cpyhi word and goes to LI_LO with `ra`/`imm[15:0]` latched. Any other accept pushes one word and stays in IDLE.
  - LI_LO: `in_ready` = 0. Pushes the ori word once FIFO count < DEPTH, then returns to IDLE.
- FIFO: circular buffer; the 32-bit word and the bad flag are stored together. `words_out` increments on each `out_valid & out_ready`.

## Timing
- `in_ready` is a function of registered state only; there is no combinational path from `out_ready`.
- Push or pop on a full FIFO:
  - Push occurs only when the registered count < DEPTH.
  - Pop in the same cycle does not enable a push that cycle.
  - Simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
- Latency:
  - Accept at edge N gives `out_valid` = 1 after edge N (from edge N+1 onward), if the FIFO was empty.
  - The second li word becomes available no earlier than one cycle after the first.
- Back-to-back accepts of single-word records sustain one word per cycle while the consumer holds `out_ready` = 1.
- Reset (asynchronous, any state, including mid-LI_LO):
  - State goes to IDLE, FIFO empties, and `words_out` = 0.
  - `out_valid` = 0, `out_word` = 0, `out_bad` = 0.
  - A pending low li word is discarded.
  - `in_ready` = 1 once `rst_n` is released.
- Holding `out_ready` = 0 with `out_valid` = 1 keeps `out_word`/`out_bad` stable.

## Test plan
- Group 0, ra=1, rb=2, rc=3, opcode 0 -> `out_word` 0x0123_0000 one cycle after accept; `out_bad` 0.
- Group 1, ra=4, rb=5, opcode 0, imm 0x1234 -> 0x1450_1234. Group 5, ra=1, rb=2, rc=3, opcode 0, imm −4 -> 0x5123_0FFC. Group 5 with imm 0x800 -> 0x5123_0800, `out_bad` = 1.
- li r7, 0xDEAD_BEEF -> 0x170E_DEAD then 0x1775_BEEF; `in_ready` low for exactly the LI_LO cycle when the FIFO has space. li r3, 0xFF -> single word 0x1305_00FF.
- Group 9, any fields -> 0x0000_0000 with `out_bad` = 1.
- Backpressure:
  - Hold `out_ready` = 0 and issue 6 single-word records: exactly 4 are accepted, and `in_ready` drops after the 4th.
  - Release `out_ready`: the words drain in order and `words_out` ends at 6 after all records are accepted.
- Assert `rst_n` low during LI_LO -> FIFO empties immediately, no ori word appears, and `words_out` = 0.
